rice_core_trap_unit: RTL and testbench

RICE_CORE_TRAP_UNIT -- requirements
Module: rice_core_trap_unit

---
 rtl/rice_core_trap_unit_if.sv | 31 +++
 rtl/rice_core_trap_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_rice_core_trap_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rice_core_trap_unit_if.sv
// -----------------------------------------------------------------------------
// rice_core_trap_unit_if
// CSR request/response bus of the trap unit.
//   master : the requester (core CSR stage); drives i_csr_*, receives o_csr_*
//   slave  : the trap unit; answers one cycle after each i_csr_valid
// Ports carried:
//   i_csr_valid, i_csr_write, i_csr_address[11:0], i_csr_wdata[XLEN-1:0]
//   o_csr_ready, o_csr_rdata[XLEN-1:0], o_csr_error
// XLEN must match the XLEN of the attached rice_core_trap_unit.
// -----------------------------------------------------------------------------
interface rice_core_trap_unit_if #(
   parameter int XLEN = 32
);
   logic            i_csr_valid;
   logic            i_csr_write;
   logic [11:0]     i_csr_address;
   logic [XLEN-1:0] i_csr_wdata;
   logic            o_csr_ready;
   logic [XLEN-1:0] o_csr_rdata;
   logic            o_csr_error;

   modport master (
      output i_csr_valid, i_csr_write, i_csr_address, i_csr_wdata,
      input  o_csr_ready, o_csr_rdata, o_csr_error
   );

   modport slave (
      input  i_csr_valid, i_csr_write, i_csr_address, i_csr_wdata,
      output o_csr_ready, o_csr_rdata, o_csr_error
   );
endinterface

// File: rtl/rice_core_trap_unit.sv
// -----------------------------------------------------------------------------
// rice_core_trap_unit
// Machine-mode trap controller: takes synchronous exceptions and interrupts,
// handles mret, and owns the M-mode trap CSRs.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable              core enable; low forces IDLE and M privilege
//   i_exception           exception requests, bit index = cause code
//   i_pc, i_tval          PC / trap value of the trapping instruction
//   i_mret                mret executed
//   i_irq_ready           core at an instruction boundary
//   i_flush_done          pipeline flush complete
//   i_msip/i_mtip/i_meip  software / timer / external interrupt lines
//   o_trap_valid/_pc      one-cycle trap redirect
//   o_return_valid/_pc    one-cycle mret redirect (target = mepc)
//   o_privilege_level     3 = M, 0 = U
//   o_busy                redirect or flush in progress
//   csr                   CSR bus (slave), answered one cycle after request
// Optional feature: define RICE_CORE_TRAP_VECTORED_EN to enable vectored
// mtvec mode (interrupts go to BASE + 4*code). Without it MODE reads 0.
// -----------------------------------------------------------------------------
module rice_core_trap_unit #(
   parameter int              XLEN            = 32,
   parameter int              EXCEPTION_WIDTH = 16,
   parameter int              EXT_IRQ         = 8,
   parameter logic [XLEN-1:0] MTVEC_RESET     = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_enable,
   input  logic [EXCEPTION_WIDTH-1:0] i_exception,
   input  logic [XLEN-1:0]            i_pc,
   input  logic [XLEN-1:0]            i_tval,
   input  logic                       i_mret,
   input  logic                       i_irq_ready,
   input  logic                       i_flush_done,
   input  logic                       i_msip,
   input  logic                       i_mtip,
   input  logic [EXT_IRQ-1:0]         i_meip,
   output logic                       o_trap_valid,
   output logic [XLEN-1:0]            o_trap_pc,
   output logic                       o_return_valid,
   output logic [XLEN-1:0]            o_return_pc,
   output logic [1:0]                 o_privilege_level,
   output logic                       o_busy,
   rice_core_trap_unit_if.slave       csr
);
   localparam int              CW      = 6;   // cause code width
   localparam logic [1:0]      PRIV_M  = 2'b11;
   localparam logic [1:0]      PRIV_U  = 2'b00;
   localparam logic [XLEN-1:0] ALIGN_M = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
   state_t state;

   // architectural state
   logic               mst_mie, mst_mpie;
   logic [1:0]         mst_mpp;
   logic               mie_msie, mie_mtie, mie_meie;
   logic [EXT_IRQ-1:0] meien;
   logic [XLEN-1:0]    mtvec_q;             // BASE only, bits[1:0] held at 0
   logic               mtvec_mode;
   logic [XLEN-1:0]    mscratch, mepc, mcause, mtval;

   // trap decision
   logic            mip_meip, en_msi, en_mti, en_mei;
   logic            exc_any, irq_take, trap_take, mret_take;
   logic [CW-1:0]   exc_code, trap_code;
   logic [XLEN-1:0] trap_target;

   assign mip_meip = |(i_meip & meien);
   assign en_mei   = mip_meip & mie_meie;
   assign en_msi   = i_msip & mie_msie;
   assign en_mti   = i_mtip & mie_mtie;

   always_comb begin
      exc_code = '0;
      for (int i = EXCEPTION_WIDTH-1; i >= 0; i--)
         if (i_exception[i]) exc_code = CW'(i);   // lowest set bit wins
      exc_any  = |i_exception;
      irq_take = i_irq_ready && (o_privilege_level == PRIV_U || mst_mie) &&
                 (en_mei || en_msi || en_mti);
      trap_take = i_enable && state == IDLE && (exc_any || irq_take);
      // an interrupt at the boundary pre-empts a simultaneous mret
      mret_take = i_enable && state == IDLE && !exc_any && !irq_take && i_mret;
      if (exc_any)     trap_code = exc_code;
      else if (en_mei) trap_code = CW'(11);
      else if (en_msi) trap_code = CW'(3);
      else             trap_code = CW'(7);
      trap_target = mtvec_q;
      if (mtvec_mode && !exc_any)
         trap_target = mtvec_q + {{(XLEN-CW-2){1'b0}}, trap_code, 2'b00};
   end

   // CSR decode (read value is the pre-write value)
   logic            csr_hit, csr_err, csr_we;
   logic [XLEN-1:0] csr_rd;

   always_comb begin
      csr_hit = 1'b1;
      csr_rd  = '0;
      case (csr.i_csr_address)
         12'h300: begin
            csr_rd[3]     = mst_mie;
            csr_rd[7]     = mst_mpie;
            csr_rd[12:11] = mst_mpp;
         end
         12'h304: begin
            csr_rd[3]  = mie_msie;
            csr_rd[7]  = mie_mtie;
            csr_rd[11] = mie_meie;
         end
         12'h305: csr_rd = {mtvec_q[XLEN-1:2], 1'b0, mtvec_mode};
         12'h340: csr_rd = mscratch;
         12'h341: csr_rd = mepc;
         12'h342: csr_rd = mcause;
         12'h343: csr_rd = mtval;
         12'h344: begin
            csr_rd[3]  = i_msip;
            csr_rd[7]  = i_mtip;
            csr_rd[11] = mip_meip;
         end
         12'h7C0: csr_rd[EXT_IRQ-1:0] = meien;
         default: csr_hit = 1'b0;
      endcase
      csr_err = (o_privilege_level == PRIV_U) || !csr_hit ||
                (csr.i_csr_write && (csr.i_csr_address == 12'h344 ||
                                     csr.i_csr_address[11:8] == 4'hF));
      csr_we  = csr.i_csr_valid && csr.i_csr_write && !csr_err;
   end

`ifndef RICE_CORE_TRAP_VECTORED_EN
   assign mtvec_mode = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state             <= IDLE;
         o_privilege_level <= PRIV_M;
         mst_mie           <= 1'b0;
         mst_mpie          <= 1'b0;
         mst_mpp           <= PRIV_U;
         mie_msie          <= 1'b0;
         mie_mtie          <= 1'b0;
         mie_meie          <= 1'b0;
         meien             <= '0;
         mtvec_q           <= MTVEC_RESET & ALIGN_M;
`ifdef RICE_CORE_TRAP_VECTORED_EN
         mtvec_mode        <= (MTVEC_RESET[1:0] == 2'b01);
`endif
         mscratch          <= '0;
         mepc              <= '0;
         mcause            <= '0;
         mtval             <= '0;
         o_trap_valid      <= 1'b0;
         o_trap_pc         <= '0;
         o_return_valid    <= 1'b0;
         o_return_pc       <= '0;
         o_busy            <= 1'b0;
         csr.o_csr_ready   <= 1'b0;
         csr.o_csr_rdata   <= '0;
         csr.o_csr_error   <= 1'b0;
      end else begin
         csr.o_csr_ready <= csr.i_csr_valid;
         if (csr.i_csr_valid) begin
            csr.o_csr_rdata <= csr_err ? '0 : csr_rd;
            csr.o_csr_error <= csr_err;
         end
         // CSR writes first so trap/mret updates below override same fields
         if (csr_we) begin
            case (csr.i_csr_address)
               12'h300: begin
                  mst_mie  <= csr.i_csr_wdata[3];
                  mst_mpie <= csr.i_csr_wdata[7];
                  mst_mpp  <= (csr.i_csr_wdata[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
               end
               12'h304: begin
                  mie_msie <= csr.i_csr_wdata[3];
                  mie_mtie <= csr.i_csr_wdata[7];
                  mie_meie <= csr.i_csr_wdata[11];
               end
               12'h305: begin
                  mtvec_q <= csr.i_csr_wdata & ALIGN_M;
`ifdef RICE_CORE_TRAP_VECTORED_EN
                  mtvec_mode <= (csr.i_csr_wdata[1:0] == 2'b01);
`endif
               end
               12'h340: mscratch <= csr.i_csr_wdata;
               12'h341: mepc     <= csr.i_csr_wdata & ALIGN_M;
               12'h342: mcause   <= csr.i_csr_wdata;
               12'h343: mtval    <= csr.i_csr_wdata;
               12'h7C0: meien    <= csr.i_csr_wdata[EXT_IRQ-1:0];
               default: ;
            endcase
         end

         o_trap_valid   <= 1'b0;
         o_return_valid <= 1'b0;
         if (!i_enable) begin
            state             <= IDLE;
            o_busy            <= 1'b0;
            o_privilege_level <= PRIV_M;
         end else begin
            case (state)
               IDLE: begin
                  if (trap_take) begin
                     state             <= REDIRECT;
                     o_busy            <= 1'b1;
                     o_trap_valid      <= 1'b1;
                     o_trap_pc         <= trap_target;
                     mepc              <= i_pc & ALIGN_M;
                     mcause            <= {!exc_any, {(XLEN-1-CW){1'b0}}, trap_code};
                     mtval             <= exc_any ? i_tval : '0;
                     mst_mpie          <= mst_mie;
                     mst_mie           <= 1'b0;
                     mst_mpp           <= o_privilege_level;
                     o_privilege_level <= PRIV_M;
                  end else if (mret_take) begin
                     state             <= REDIRECT;
                     o_busy            <= 1'b1;
                     o_return_valid    <= 1'b1;
                     o_return_pc       <= mepc;
                     mst_mie           <= mst_mpie;
                     mst_mpie          <= 1'b1;
                     o_privilege_level <= mst_mpp;
                     mst_mpp           <= PRIV_U;
                  end
               end
               REDIRECT: state <= FLUSH;
               FLUSH: begin
                  if (i_flush_done) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rice_core_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_rice_core_trap_unit
// Directed scenarios plus randomized CSR traffic and trap/mret events,
// checked against an architectural model of the trap rules.
// -----------------------------------------------------------------------------
module tb_rice_core_trap_unit;
`ifdef RICE_CORE_TRAP_VECTORED_EN
   localparam bit VECT = 1'b1;
`else
   localparam bit VECT = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_enable, i_mret, i_irq_ready, i_flush_done;
   logic        i_msip, i_mtip;
   logic [15:0] i_exception;
   logic [31:0] i_pc, i_tval;
   logic [7:0]  i_meip;
   logic        o_trap_valid, o_return_valid, o_busy;
   logic [31:0] o_trap_pc, o_return_pc;
   logic [1:0]  o_privilege_level;

   always #5 i_clk = ~i_clk;

   rice_core_trap_unit_if #(.XLEN(32)) csr_if ();

   rice_core_trap_unit #(
      .XLEN(32), .EXCEPTION_WIDTH(16), .EXT_IRQ(8), .MTVEC_RESET(32'h0)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
      .i_exception(i_exception), .i_pc(i_pc), .i_tval(i_tval),
      .i_mret(i_mret), .i_irq_ready(i_irq_ready), .i_flush_done(i_flush_done),
      .i_msip(i_msip), .i_mtip(i_mtip), .i_meip(i_meip),
      .o_trap_valid(o_trap_valid), .o_trap_pc(o_trap_pc),
      .o_return_valid(o_return_valid), .o_return_pc(o_return_pc),
      .o_privilege_level(o_privilege_level), .o_busy(o_busy),
      .csr(csr_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // ---------------- architectural model ----------------
   bit [1:0]  m_priv, m_mpp;
   bit        m_mie, m_mpie;
   bit [31:0] m_iecsr, m_meien, m_mtvec, m_mepc, m_mcause, m_mtval, m_scratch;

   function automatic void model_reset();
      m_priv = 3; m_mpp = 0; m_mie = 0; m_mpie = 0;
      m_iecsr = 0; m_meien = 0; m_mtvec = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_scratch = 0;
   endfunction

   function automatic bit [31:0] model_read(input bit [11:0] a, output bit hit);
      hit = 1;
      case (a)
         12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7) | (32'(m_mpp) << 11);
         12'h304: return m_iecsr;
         12'h305: return m_mtvec;
         12'h340: return m_scratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return (32'(i_msip) << 3) | (32'(i_mtip) << 7) |
                         (32'((i_meip & m_meien[7:0]) != 0) << 11);
         12'h7C0: return m_meien;
         default: begin hit = 0; return 0; end
      endcase
   endfunction

   function automatic void model_write(input bit [11:0] a, input bit [31:0] d);
      case (a)
         12'h300: begin
            m_mie = d[3]; m_mpie = d[7];
            m_mpp = (d[12:11] == 2'd3) ? 2'd3 : 2'd0;
         end
         12'h304: m_iecsr  = d & 32'h888;
         12'h305: m_mtvec  = (d & ~32'h3) | ((VECT && d[1:0] == 2'd1) ? 32'd1 : 32'd0);
         12'h340: m_scratch = d;
         12'h341: m_mepc   = d & ~32'h3;
         12'h342: m_mcause = d;
         12'h343: m_mtval  = d;
         12'h7C0: m_meien  = d & 32'hFF;
         default: ;
      endcase
   endfunction

   // one CSR access; expected response comes from the model
   task automatic csr_op(input bit wr, input bit [11:0] a, input bit [31:0] wd,
                         output logic [31:0] rd, output logic err);
      bit hit;
      bit [31:0] exp_rd;
      bit exp_err;
      exp_rd  = model_read(a, hit);
      exp_err = (m_priv == 0) || !hit || (wr && (a == 12'h344 || a >= 12'hF00));
      csr_if.i_csr_valid   = 1'b1;
      csr_if.i_csr_write   = wr;
      csr_if.i_csr_address = a;
      csr_if.i_csr_wdata   = wd;
      step();
      csr_if.i_csr_valid = 1'b0;
      csr_if.i_csr_write = 1'b0;
      rd  = csr_if.o_csr_rdata;
      err = csr_if.o_csr_error;
      check("csr_ready", csr_if.o_csr_ready, 1);
      check("csr_error", err, exp_err);
      check("csr_rdata", rd, exp_err ? 32'd0 : exp_rd);
      if (wr && !exp_err) model_write(a, wd);
   endtask

   task automatic clear_inputs();
      i_exception = 0; i_msip = 0; i_mtip = 0; i_meip = 0;
      i_irq_ready = 0; i_mret = 0; i_flush_done = 0;
   endtask

   // one event cycle in IDLE, then the redirect/flush sequence if anything was taken
   task automatic trap_event(input bit [15:0] exc, input bit msip, input bit mtip,
                             input bit [7:0] meip, input bit rdy, input bit mret,
                             input bit [31:0] pc, input bit [31:0] tval);
      int kind, code, extra;
      bit irq, e, s, t;
      bit [31:0] exp_tgt, exp_ret;
      kind = 0; code = 0; irq = 0;
      if (exc != 0) begin
         kind = 1;
         for (int i = 15; i >= 0; i--) if (exc[i]) code = i;
      end else if (rdy && (m_priv == 0 || m_mie)) begin
         e = m_iecsr[11] && ((meip & m_meien[7:0]) != 0);
         s = m_iecsr[3] && msip;
         t = m_iecsr[7] && mtip;
         if (e) code = 11; else if (s) code = 3; else if (t) code = 7;
         if (e || s || t) begin kind = 1; irq = 1; end
      end
      if (kind == 0 && mret) kind = 2;
      exp_tgt = (m_mtvec & ~32'h3) + ((VECT && m_mtvec[1:0] == 2'd1 && irq) ? 32'(4 * code) : 0);
      exp_ret = m_mepc;

      i_exception = exc; i_msip = msip; i_mtip = mtip; i_meip = meip;
      i_irq_ready = rdy; i_mret = mret; i_pc = pc; i_tval = tval;
      step();
      clear_inputs();
      check("trap_valid", o_trap_valid, kind == 1);
      check("return_valid", o_return_valid, kind == 2);
      check("busy", o_busy, kind != 0);
      if (kind == 1) check("trap_pc", o_trap_pc, exp_tgt);
      if (kind == 2) check("return_pc", o_return_pc, exp_ret);

      if (kind == 1) begin
         m_mepc = pc & ~32'h3; m_mcause = (32'(irq) << 31) | 32'(code);
         m_mtval = irq ? 0 : tval; m_mpie = m_mie; m_mie = 0;
         m_mpp = m_priv; m_priv = 3;
      end else if (kind == 2) begin
         m_mie = m_mpie; m_mpie = 1; m_priv = m_mpp; m_mpp = 0;
      end
      check("priv", o_privilege_level, m_priv);

      if (kind != 0) begin
         // requests arriving while busy must be ignored
         extra = $urandom_range(0, 2);
         for (int c = 0; c <= extra + 1; c++) begin
            i_exception = 16'(1 << $urandom_range(0, 15));
            i_msip = 1; i_mtip = 1; i_meip = 8'hFF; i_irq_ready = 1; i_mret = 1;
            i_flush_done = (c == extra + 1);
            step();
            check("busy_no_trap", o_trap_valid, 0);
            check("busy_no_ret", o_return_valid, 0);
            check("busy_level", o_busy, c != extra + 1);
         end
         clear_inputs();
      end
   endtask

   logic [31:0] rd;
   logic        err;
   bit [11:0]   addr_tbl [0:11];
   bit [15:0]   rexc;

   initial begin
      addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                   12'h343, 12'h344, 12'h7C0, 12'hF11, 12'h123, 12'h301};
      clear_inputs();
      i_pc = 0; i_tval = 0; i_enable = 1; i_rst_n = 0;
      csr_if.i_csr_valid = 0; csr_if.i_csr_write = 0;
      csr_if.i_csr_address = 0; csr_if.i_csr_wdata = 0;
      model_reset();
      step(); step();
      check("rst_trap_valid", o_trap_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_csr_ready", csr_if.o_csr_ready, 0);
      check("rst_csr_rdata", csr_if.o_csr_rdata, 0);
      check("rst_priv", o_privilege_level, 3);
      @(negedge i_clk); i_rst_n = 1;
      step();
      csr_op(0, 12'h305, 0, rd, err);
      csr_op(0, 12'h300, 0, rd, err);

      // exception code 2 at pc 0x100
      csr_op(1, 12'h305, 32'h80, rd, err);
      trap_event(16'h0004, 0, 0, 0, 0, 0, 32'h100, 32'hDEAD);
      check("exc2_pc", o_trap_pc, 32'h80);
      csr_op(0, 12'h342, 0, rd, err); check("exc2_mcause", rd, 2);
      csr_op(0, 12'h341, 0, rd, err); check("exc2_mepc", rd, 32'h100);
      csr_op(0, 12'h300, 0, rd, err); check("exc2_mie", rd[3], 0);
      csr_op(0, 12'h343, 0, rd, err);

      // U-mode timer interrupt with MIE=0
      csr_op(1, 12'h304, 32'h080, rd, err);
      csr_op(1, 12'h300, 32'h0, rd, err);
      trap_event(0, 0, 0, 0, 0, 1, 0, 0);
      check("umode", o_privilege_level, 0);
      trap_event(0, 0, 1, 0, 1, 0, 32'h204, 0);
      check("mti_priv", o_privilege_level, 3);
      csr_op(0, 12'h342, 0, rd, err); check("mti_mcause", rd, 32'h80000007);

      // MEI > MSI > MTI, then MSI after mret
      csr_op(1, 12'h7C0, 32'h1, rd, err);
      csr_op(1, 12'h304, 32'h888, rd, err);
      csr_op(1, 12'h300, 32'h1808, rd, err);
      trap_event(0, 1, 1, 8'h01, 1, 0, 32'h300, 0);
      csr_op(0, 12'h342, 0, rd, err); check("mei_mcause", rd, 32'h8000000B);
      trap_event(0, 0, 0, 0, 0, 1, 0, 0);
      trap_event(0, 1, 1, 0, 1, 0, 32'h304, 0);
      csr_op(0, 12'h342, 0, rd, err); check("msi_mcause", rd, 32'h80000003);
      csr_op(0, 12'h344, 0, rd, err);

      // exception beats same-cycle mret
      trap_event(16'h0110, 0, 0, 0, 0, 1, 32'h403, 32'h77);

      // vectored / direct mtvec targets
      csr_op(1, 12'h305, 32'h201, rd, err);
      csr_op(1, 12'h300, 32'h1808, rd, err);
      trap_event(0, 0, 0, 8'h01, 1, 0, 32'h500, 0);
      check("mei_target", o_trap_pc, VECT ? 32'h22C : 32'h200);
      trap_event(16'h0008, 0, 0, 0, 0, 0, 32'h504, 0);
      check("exc_target", o_trap_pc, 32'h200);

      // CSR errors: U mode, read-only, unimplemented, WARL MPP
      csr_op(1, 12'h300, 32'h0, rd, err);
      trap_event(0, 0, 0, 0, 0, 1, 0, 0);
      csr_op(0, 12'h300, 0, rd, err); check("umode_csr_err", err, 1);
      trap_event(16'h0100, 0, 0, 0, 0, 0, 32'h600, 0);
      csr_op(1, 12'h300, 32'h1000, rd, err);
      csr_op(0, 12'h300, 0, rd, err); check("mpp_warl", rd[12:11], 0);
      csr_op(1, 12'h344, 32'hFFFF, rd, err); check("mip_wr_err", err, 1);
      csr_op(1, 12'hF11, 32'h1, rd, err);
      csr_op(0, 12'h123, 0, rd, err);

      // core disabled: exception not taken, privilege stays M
      i_enable = 0; i_exception = 16'h0001;
      step();
      check("dis_trap", o_trap_valid, 0);
      check("dis_busy", o_busy, 0);
      check("dis_priv", o_privilege_level, 3);
      i_enable = 1; clear_inputs();

      // reset in FLUSH abandons the trap
      i_exception = 16'h0002; i_pc = 32'h700;
      step(); clear_inputs(); step();
      check("flush_busy", o_busy, 1);
      #2 i_rst_n = 0;
      #1 check("rstf_busy", o_busy, 0);
      model_reset();
      @(negedge i_clk); i_rst_n = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("rstf_no_trap", o_trap_valid, 0);
      end
      csr_op(0, 12'h341, 0, rd, err);

      // randomized traffic
      for (int it = 0; it < 200; it++) begin
         for (int k = $urandom_range(0, 2); k > 0; k--)
            csr_op($urandom_range(0, 1), addr_tbl[$urandom_range(0, 11)], $urandom, rd, err);
         case ($urandom_range(0, 3))
            0: rexc = 0;
            1: rexc = 16'(1 << $urandom_range(0, 15));
            default: rexc = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
         endcase
         if ($urandom_range(0, 4) == 0)
            trap_event(rexc, 0, 0, 0, 0, 1, $urandom, $urandom);
         else
            trap_event(rexc, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                       0, $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
